// File: rtl/fft_pkg.sv
// Shared constants and FSM encodings for the FFT frame scheduler.
// Default frame and timing values; the top module turns them into overridable parameters.
package fft_pkg;

  localparam int DEF_N_PTS    = 16;
  localparam int DEF_CNT_W    = 5;
  localparam int DEF_CORE_LAT = 9;
  localparam int DEF_SP_HOLD  = 4;
  localparam int DEF_FRM_W    = 8;

  typedef enum logic [1:0] {
    IN_FILL = 2'd0,
    IN_FULL = 2'd1,
    IN_HOLD = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE  = 2'd0,
    O_RUN   = 2'd1,
    O_DRAIN = 2'd2
  } out_state_t;

endpackage

// File: rtl/fft_sched_cnt.sv
// Up-counter with enable, sync clear and terminal-count flag.
// It wraps to zero on the enabled cycle where it sits at MAX.
module fft_sched_cnt #(
  parameter int W   = 5,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign tc = (cnt == MAX_V);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame-level scheduler for the 16-point FFT: paces s_p fill, core start and p_s drain.
// Handshake: a transfer happens on a side exactly when valid & ready are high in the same cycle.
module fft_frame_sched
  import fft_pkg::*;
#(
  parameter int N_PTS    = DEF_N_PTS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CORE_LAT = DEF_CORE_LAT,
  parameter int SP_HOLD  = DEF_SP_HOLD,
  parameter int FRM_W    = DEF_FRM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sp_shift_en,
  output logic             core_start,
  output logic             ps_load,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             ps_shift_en,
  output logic             busy,
  output logic [FRM_W-1:0] frame_cnt,
  output in_state_t        dbg_in_state,
  output out_state_t       dbg_out_state,
  output logic [CNT_W-1:0] dbg_in_cnt,
  output logic [CNT_W-1:0] dbg_out_cnt,
  output logic [CNT_W-1:0] dbg_hold_cnt,
  output logic [CNT_W-1:0] dbg_lat_cnt
);

  in_state_t        in_state, in_state_nxt;
  out_state_t       out_state, out_state_nxt;
  logic [CNT_W-1:0] in_cnt, out_cnt, hold_cnt, lat_cnt;
  logic             in_tc, out_tc, hold_tc, lat_tc;

  assign sp_shift_en = in_valid & in_ready;
  assign ps_shift_en = out_valid & out_ready;
  // busy comes from registered state only, so out_ready never reaches in_ready.
  assign busy        = (out_state != O_IDLE);

  fft_sched_cnt #(.W(CNT_W), .MAX(N_PTS - 1)) u_in_cnt (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (sp_shift_en),
    .cnt (in_cnt),
    .tc  (in_tc)
  );

  fft_sched_cnt #(.W(CNT_W), .MAX(SP_HOLD - 1)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (in_state == IN_HOLD),
    .cnt (hold_cnt),
    .tc  (hold_tc)
  );

  fft_sched_cnt #(.W(CNT_W), .MAX(CORE_LAT - 1)) u_lat_cnt (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (out_state == O_RUN),
    .cnt (lat_cnt),
    .tc  (lat_tc)
  );

  fft_sched_cnt #(.W(CNT_W), .MAX(N_PTS - 1)) u_out_cnt (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (ps_shift_en),
    .cnt (out_cnt),
    .tc  (out_tc)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      in_state  <= IN_FILL;
      out_state <= O_IDLE;
    end else begin
      in_state  <= in_state_nxt;
      out_state <= out_state_nxt;
    end
  end

  // Input side: fill s_p, wait for the core to be free, then keep s_p frozen while it is read.
  always_comb begin
    in_state_nxt = in_state;
    in_ready     = 1'b0;
    core_start   = 1'b0;
    case (in_state)
      IN_FILL: begin
        in_ready = 1'b1;
        if (in_valid && in_tc) in_state_nxt = IN_FULL;
      end
      IN_FULL: begin
        if (!busy) begin
          core_start   = ~flush;
          in_state_nxt = IN_HOLD;
        end
      end
      IN_HOLD: begin
        if (hold_tc) in_state_nxt = IN_FILL;
      end
      default: in_state_nxt = IN_FILL;
    endcase
  end

  // Core/output side: wait out the core latency, load p_s, then drain one frame.
  always_comb begin
    out_state_nxt = out_state;
    ps_load       = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    case (out_state)
      O_IDLE: begin
        if (core_start) out_state_nxt = O_RUN;
      end
      O_RUN: begin
        if (lat_tc) begin
          ps_load       = ~flush;
          out_state_nxt = O_DRAIN;
        end
      end
      O_DRAIN: begin
        out_valid = 1'b1;
        out_last  = out_tc;
        if (out_ready && out_tc) out_state_nxt = O_IDLE;
      end
      default: out_state_nxt = O_IDLE;
    endcase
  end

  // A frame aborted by flush in its final accept cycle is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (!flush && ps_shift_en && out_tc) begin
      frame_cnt <= frame_cnt + FRM_W'(1);
    end
  end

  assign dbg_in_state  = in_state;
  assign dbg_out_state = out_state;
  assign dbg_in_cnt    = in_cnt;
  assign dbg_out_cnt   = out_cnt;
  assign dbg_hold_cnt  = hold_cnt;
  assign dbg_lat_cnt   = lat_cnt;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: directed frames, cycle-stamped expectations in queues,
// and a negedge monitor that pops and compares whenever the DUT signals an event.
module tb_fft_frame_sched;
  import fft_pkg::*;

  localparam int W = 37;  // {cycle[31:0], last, index[3:0]}

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic       in_ready, sp_shift_en, core_start, ps_load;
  logic       out_valid, out_last, ps_shift_en, busy;
  logic [7:0] frame_cnt;
  in_state_t  dbg_in_state;
  out_state_t dbg_out_state;
  logic [4:0] dbg_in_cnt, dbg_out_cnt, dbg_hold_cnt, dbg_lat_cnt;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_in_acc = 0;
  int         n_out_acc = 0;
  bit         mon_en = 1'b0;
  int         acc_q[$];
  int         start_q[$];
  int         load_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic       prev_ov = 1'b0;
  logic       prev_acc = 1'b0;
  logic       prev_fl = 1'b1;
  int         base;

  fft_frame_sched dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sp_shift_en   (sp_shift_en),
    .core_start    (core_start),
    .ps_load       (ps_load),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .ps_shift_en   (ps_shift_en),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .dbg_in_state  (dbg_in_state),
    .dbg_out_state (dbg_out_state),
    .dbg_in_cnt    (dbg_in_cnt),
    .dbg_out_cnt   (dbg_out_cnt),
    .dbg_hold_cnt  (dbg_hold_cnt),
    .dbg_lat_cnt   (dbg_lat_cnt)
  );

  // Clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (sp_shift_en) begin
        n_in_acc++;
        if (acc_q.size() == 0) chk("in_accept_unexpected", cyc, -1);
        else chk("in_accept_cycle", cyc, acc_q.pop_front());
      end
      if (core_start) begin
        if (start_q.size() == 0) chk("core_start_unexpected", cyc, -1);
        else chk("core_start_cycle", cyc, start_q.pop_front());
      end
      if (ps_load) begin
        if (load_q.size() == 0) chk("ps_load_unexpected", cyc, -1);
        else chk("ps_load_cycle", cyc, load_q.pop_front());
      end
      if (ps_shift_en) begin
        n_out_acc++;
        if (exp_q.size() == 0) chk("out_accept_unexpected", cyc, -1);
        else begin
          e = exp_q.pop_front();
          chk("out_accept_cycle", cyc, int'(e[36:5]));
          chk("out_last", int'(out_last), int'(e[4]));
          chk("out_index", int'(dbg_out_cnt), int'(e[3:0]));
        end
      end
      if (prev_ov && !prev_acc && !prev_fl) chk("out_valid_held", int'(out_valid), 1);
    end
    prev_ov  = out_valid;
    prev_acc = ps_shift_en;
    prev_fl  = flush | rst;
  end

  // Streams n frames from an idle scheduler with in_valid held high; with tog, out_ready
  // alternates 1,0,1,0 from the first drain cycle of each frame.
  task automatic stream_frames(input int n, input bit tog);
    int b, s0, d, s, last_acc, t_end, r;
    b  = cyc;
    s0 = b + 16;
    d  = tog ? 41 : 26;
    for (int k = 0; k < n; k++) begin
      s = s0 + d * k;
      start_q.push_back(s);
      load_q.push_back(s + 9);
      for (int i = 0; i < 16; i++) begin
        acc_q.push_back((k == 0) ? b + i : s - d + 5 + i);
        exp_q.push_back({32'(tog ? s + 10 + 2 * i : s + 10 + i), 1'(i == 15), 4'(i)});
      end
    end
    last_acc = (n == 1) ? b + 15 : s0 + d * (n - 2) + 20;
    t_end    = s0 + d * (n - 1) + d + 2;
    for (int t = b; t <= t_end; t++) begin
      in_valid  = (t <= last_acc);
      r         = (t >= s0) ? (t - s0) % d : 0;
      out_ready = !tog || (r < 10) || ((r - 10) % 2 == 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);
    chk("reset_core_start", int'(core_start), 0);
    chk("reset_ps_load", int'(ps_load), 0);
    chk("reset_in_cnt", int'(dbg_in_cnt), 0);
    step();

    // Two back-to-back frames: hold window and start gated by drain
    stream_frames(2, 1'b0);
    @(negedge clk);
    chk("a_frame_cnt", int'(frame_cnt), 2);
    chk("a_busy", int'(busy), 0);
    chk("a_in_ready", int'(in_ready), 1);
    step();

    // Output backpressure 1,0,1,0
    stream_frames(1, 1'b1);
    @(negedge clk);
    chk("b_frame_cnt", int'(frame_cnt), 3);
    chk("b_out_valid", int'(out_valid), 0);
    step();

    // Flush with a partial frame of 7 samples
    base = cyc;
    for (int i = 0; i < 7; i++) begin
      acc_q.push_back(base + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    chk("c_in_cnt_before_flush", int'(dbg_in_cnt), 7);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("c_in_cnt_after_flush", int'(dbg_in_cnt), 0);
    chk("c_in_ready_after_flush", int'(in_ready), 1);
    chk("c_busy_after_flush", int'(busy), 0);
    step();
    stream_frames(1, 1'b0);
    @(negedge clk);
    chk("c_frame_cnt", int'(frame_cnt), 4);
    step();

    // Flush while the core runs, three cycles after core_start
    base = cyc;
    for (int i = 0; i < 16; i++) acc_q.push_back(base + i);
    start_q.push_back(base + 16);
    for (int t = 0; t < 19; t++) begin
      in_valid = (t < 16);
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    chk("d_busy_in_run", int'(busy), 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("d_busy_after_flush", int'(busy), 0);
    chk("d_out_valid_after_flush", int'(out_valid), 0);
    chk("d_in_ready_after_flush", int'(in_ready), 1);
    chk("d_lat_cnt_after_flush", int'(dbg_lat_cnt), 0);
    chk("d_frame_cnt_after_flush", int'(frame_cnt), 4);
    step();
    repeat (30) step();
    @(negedge clk);
    chk("d_out_valid_later", int'(out_valid), 0);
    chk("d_frame_cnt_later", int'(frame_cnt), 4);
    step();

    // Reset, then 256 continuous frames so frame_cnt wraps
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("e_frame_cnt_reset", int'(frame_cnt), 0);
    step();
    n_in_acc  = 0;
    n_out_acc = 0;
    stream_frames(256, 1'b0);
    @(negedge clk);
    chk("e_frame_cnt_wrap", int'(frame_cnt), 0);
    chk("e_in_accepts", n_in_acc, 4096);
    chk("e_out_accepts", n_out_acc, 4096);
    chk("e_busy", int'(busy), 0);

    chk("left_in_accepts", acc_q.size(), 0);
    chk("left_core_starts", start_q.size(), 0);
    chk("left_ps_loads", load_q.size(), 0);
    chk("left_out_accepts", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
